psum_allreduce_hub: RTL and testbench

//  Single-clock all-reduce exchange for NCORE normalisation cores; generalises the two-core psum swap.

---
 rtl/psum_pkg.sv | 25 ++
 rtl/psum_allreduce_hub_if.sv | 36 +++
 rtl/psum_sync_fifo.sv | 60 ++++++
 rtl/psum_allreduce_hub.sv | 145 ++++++++++++++
 tb/tb_psum_allreduce_hub.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum all-reduce hub.
//   mode_e    : reduction mode broadcast with each result (TOTAL / OTHERS)
//   state_e   : output bank state (IDLE / HOLD)
//   CNT_W     : width of the completed-reduction counter
//   sum_width : result width that can hold the sum of n bw-bit values
package psum_pkg;

  typedef enum logic {
    MODE_TOTAL  = 1'b0,
    MODE_OTHERS = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int unsigned CNT_W = 16;

  // Growth of log2(n) bits keeps an n-way signed sum from overflowing.
  function automatic int unsigned sum_width(input int unsigned bw, input int unsigned n);
    return bw + $clog2(n);
  endfunction

endpackage

// File: rtl/psum_allreduce_hub_if.sv
// Core-array <-> hub bus for the partial-sum all-reduce hub.
//   in_wr/in_data/in_ready : per-core push side (core k at [k*BW +: BW])
//   mode                   : 0 = TOTAL, 1 = OTHERS
//   out_valid/out_data     : broadcast result bank (core k at [k*SW +: SW])
//   out_ack                : per-core consume strobe
//   ovf_err                : sticky per-core overflow flags
//   red_cnt                : completed reductions
// master = core array side, slave = hub side.
interface psum_allreduce_hub_if #(
  parameter int unsigned NCORE = 4,
  parameter int unsigned BW    = 24
);

  localparam int unsigned SW = psum_pkg::sum_width(BW, NCORE);

  logic [NCORE-1:0]             in_wr;
  logic [NCORE*BW-1:0]          in_data;
  logic [NCORE-1:0]             in_ready;
  logic                         mode;
  logic                         out_valid;
  logic [NCORE*SW-1:0]          out_data;
  logic [NCORE-1:0]             out_ack;
  logic [NCORE-1:0]             ovf_err;
  logic [psum_pkg::CNT_W-1:0]   red_cnt;

  modport master (
    output in_wr, in_data, mode, out_ack,
    input  in_ready, out_valid, out_data, ovf_err, red_cnt
  );

  modport slave (
    input  in_wr, in_data, mode, out_ack,
    output in_ready, out_valid, out_data, ovf_err, red_cnt
  );

endinterface

// File: rtl/psum_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and registered flags.
//   clk, rst_n : clock, async active-low reset
//   wr, wdata  : push strobe/data (ignored while full)
//   rd         : pop strobe (ignored while empty)
//   head       : oldest entry, valid whenever empty=0
//   full/empty : registered status flags
module psum_sync_fifo #(
  parameter int unsigned BW    = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [BW-1:0] wdata,
  input  logic          rd,
  output logic [BW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [BW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic [AW:0]   wptr_d, rptr_d;
  logic          push, pop;

  assign push = wr && !full;
  assign pop  = rd && !empty;
  assign head = mem_q[rptr_q[AW-1:0]];

  // Next pointers; the extra MSB distinguishes full from empty on equal index.
  always_comb begin
    wptr_d = wptr_q + (AW+1)'(push);
    rptr_d = rptr_q + (AW+1)'(pop);
  end

  // Pointer and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      empty  <= (wptr_d == rptr_d);
      full   <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/psum_allreduce_hub.sv
// All-reduce exchange for NCORE cores: one FIFO per core, a lock-step pop
// when every FIFO holds data, and a registered broadcast of either the
// global total or total-minus-own to every core.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : core-array bus (slave side), see psum_allreduce_hub_if
module psum_allreduce_hub
  import psum_pkg::*;
#(
  parameter int unsigned NCORE = 4,
  parameter int unsigned BW    = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  psum_allreduce_hub_if.slave bus
);

  localparam int unsigned SW = sum_width(BW, NCORE);
  localparam int unsigned XW = SW - BW;

  logic [NCORE-1:0]    full;
  logic [NCORE-1:0]    empty;
  logic [BW-1:0]       head [NCORE];
  logic [SW-1:0]       ext  [NCORE];
  logic [SW-1:0]       res  [NCORE];
  logic [SW-1:0]       total;
  mode_e               mode_s;

  state_e              state_q, state_d;
  logic [NCORE-1:0]    ack_q, ack_d;
  logic                acks_all;
  logic                fire;

  logic                valid_q;
  logic [NCORE*SW-1:0] data_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NCORE-1:0]    ovf_q;

  // Per-core input FIFOs, all popped together on fire
  for (genvar k = 0; k < NCORE; k++) begin : g_fifo
    psum_sync_fifo #(
      .BW    (BW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .wr    (bus.in_wr[k]),
      .wdata (bus.in_data[k*BW +: BW]),
      .rd    (fire),
      .head  (head[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  assign bus.in_ready  = ~full;
  assign bus.ovf_err   = ovf_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.red_cnt   = cnt_q;
  assign mode_s        = mode_e'(bus.mode);

  // Adder tree over sign-extended heads, then per-core OTHERS subtraction
  always_comb begin
    total = '0;
    for (int unsigned k = 0; k < NCORE; k++) begin
      ext[k] = {{XW{head[k][BW-1]}}, head[k]};
      total  = total + ext[k];
    end
    for (int unsigned k = 0; k < NCORE; k++) begin
      res[k] = (mode_s == MODE_OTHERS) ? (total - ext[k]) : total;
    end
  end

  // Ack FSM next state; fire may coincide with the last ack to avoid a bubble
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    fire     = 1'b0;
    acks_all = &(ack_q | bus.out_ack);
    case (state_q)
      ST_IDLE: begin
        fire  = ~|empty;
        ack_d = '0;
        if (fire) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        fire = (~|empty) && acks_all;
        if (fire) begin
          ack_d = '0;
        end else if (acks_all) begin
          state_d = ST_IDLE;
          ack_d   = '0;
        end else begin
          ack_d = ack_q | bus.out_ack;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = '0;
      end
    endcase
  end

  // FSM state and ack mask
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // Result bank; mode is captured implicitly through res at fire
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= (state_d == ST_HOLD);
      if (fire) begin
        cnt_q <= cnt_q + CNT_W'(1);
        for (int unsigned k = 0; k < NCORE; k++) begin
          data_q[k*SW +: SW] <= res[k];
        end
      end
    end
  end

  // Sticky overflow: a push presented while the FIFO is full is dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_q | (bus.in_wr & full);
    end
  end

endmodule

// File: tb/tb_psum_allreduce_hub.sv
// Directed bench for psum_allreduce_hub with a queue-based reference model
// and literal spot checks on hand-computed results.
module tb_psum_allreduce_hub;
  import psum_pkg::*;

  localparam int unsigned NCORE = 4;
  localparam int unsigned BW    = 24;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SW    = sum_width(BW, NCORE);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  psum_allreduce_hub_if #(.NCORE(NCORE), .BW(BW)) bus ();

  psum_allreduce_hub #(.NCORE(NCORE), .BW(BW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint   mq [NCORE][$];
  bit       m_valid = 1'b0;
  bit [3:0] m_acked = '0;
  bit [3:0] m_ovf   = '0;
  longint   m_res [NCORE];
  int       m_cnt = 0;

  always @(posedge clk or negedge reset) begin : model
    bit       all_ne;
    bit       all_ack;
    bit       do_fire;
    bit [3:0] was_full;
    longint   tot;
    longint   h [NCORE];
    if (!reset) begin
      for (int k = 0; k < NCORE; k++) mq[k].delete();
      m_valid = 1'b0;
      m_acked = '0;
      m_ovf   = '0;
      m_cnt   = 0;
    end else begin
      all_ne = 1'b1;
      for (int k = 0; k < NCORE; k++) begin
        if (mq[k].size() == 0) all_ne = 1'b0;
        was_full[k] = (mq[k].size() >= DEPTH);
      end
      all_ack = ((m_acked | bus.out_ack) == 4'hF);
      do_fire = all_ne && (!m_valid || all_ack);
      if (do_fire) begin
        tot = 0;
        for (int k = 0; k < NCORE; k++) begin
          h[k] = mq[k].pop_front();
          tot  = tot + h[k];
        end
        for (int k = 0; k < NCORE; k++) m_res[k] = bus.mode ? (tot - h[k]) : tot;
        m_valid = 1'b1;
        m_acked = '0;
        m_cnt   = (m_cnt + 1) % 65536;
      end else if (m_valid) begin
        m_acked = m_acked | bus.out_ack;
        if (m_acked == 4'hF) begin
          m_valid = 1'b0;
          m_acked = '0;
        end
      end
      for (int k = 0; k < NCORE; k++) begin
        if (bus.in_wr[k]) begin
          if (was_full[k]) m_ovf[k] = 1'b1;
          else mq[k].push_back(longint'($signed(bus.in_data[k*BW +: BW])));
        end
      end
    end
  end

  function automatic longint dout(input int k);
    logic signed [SW-1:0] d;
    d = bus.out_data[k*SW +: SW];
    return longint'(d);
  endfunction

  // Every-cycle compare against the model, away from the active edge
  always @(negedge clk) begin : compare
    chk("out_valid", bus.out_valid, m_valid);
    chk("red_cnt", bus.red_cnt, m_cnt);
    for (int k = 0; k < NCORE; k++) begin
      chk($sformatf("in_ready[%0d]", k), bus.in_ready[k], mq[k].size() < DEPTH);
      chk($sformatf("ovf_err[%0d]", k), bus.ovf_err[k], m_ovf[k]);
      if (m_valid) chk($sformatf("out_data[%0d]", k), dout(k), m_res[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input longint v0, input longint v1, input longint v2,
                       input longint v3, input logic [3:0] m);
    bus.in_data = {BW'(v3), BW'(v2), BW'(v1), BW'(v0)};
    bus.in_wr   = m;
    tick();
    bus.in_wr   = '0;
  endtask

  task automatic ack_all();
    bus.out_ack = 4'hF;
    tick();
    bus.out_ack = '0;
  endtask

  initial begin : stim
    int n;
    bus.in_wr   = '0;
    bus.in_data = '0;
    bus.mode    = 1'b0;
    bus.out_ack = '0;
    #1 reset = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst in_ready", bus.in_ready, 4'hF);
    chk("rst red_cnt", bus.red_cnt, 0);
    chk("rst ovf_err", bus.ovf_err, 0);
    chk("rst out_data zero", bus.out_data == '0, 1);
    reset = 1'b1;
    tick();

    // TOTAL: 5 - 3 + 7 + 1 = 10 for every core
    push4(5, -3, 7, 1, 4'hF);
    chk("total pre-valid", bus.out_valid, 0);
    tick();
    chk("total out_valid", bus.out_valid, 1);
    for (int k = 0; k < NCORE; k++) chk($sformatf("total data[%0d]", k), dout(k), 10);
    chk("total red_cnt", bus.red_cnt, 1);
    ack_all();
    chk("total idle", bus.out_valid, 0);

    // OTHERS: 10 - own -> {5,13,3,9}; mode flip mid-hold leaves data alone
    bus.mode = 1'b1;
    push4(5, -3, 7, 1, 4'hF);
    tick();
    bus.mode = 1'b0;
    chk("others d0", dout(0), 5);
    chk("others d1", dout(1), 13);
    chk("others d2", dout(2), 3);
    chk("others d3", dout(3), 9);
    tick();
    chk("others held d1", dout(1), 13);
    ack_all();

    // Skew: core 3 silent -> nothing issues
    for (int i = 0; i < 3; i++) push4(10*i, 10*i + 1, 10*i + 2, 0, 4'b0111);
    repeat (3) tick();
    chk("skew no valid", bus.out_valid, 0);
    for (int i = 0; i < 3; i++) push4(0, 0, 0, 100 + i, 4'b1000);
    chk("skew first total", dout(0), 103);
    n = 0;
    for (int g = 0; g < 20 && n < 3; g++) begin
      if (bus.out_valid) begin
        ack_all();
        n++;
      end else begin
        tick();
      end
    end
    chk("skew results", n, 3);
    chk("skew red_cnt", bus.red_cnt, 5);
    chk("skew drained", bus.out_valid, 0);

    // Ack overlap with the next set already queued
    push4(1, 2, 3, 4, 4'hF);
    push4(-8, 20, 0, 3, 4'hF);
    chk("ovl first", dout(2), 10);
    bus.out_ack = 4'b0011;
    tick();
    bus.out_ack = 4'b0001;
    tick();
    chk("ovl still held", dout(0), 10);
    bus.out_ack = 4'b1100;
    tick();
    bus.out_ack = '0;
    chk("ovl valid n+3", bus.out_valid, 1);
    chk("ovl new data", dout(0), 15);
    chk("ovl red_cnt", bus.red_cnt, 7);
    ack_all();
    chk("ovl idle", bus.out_valid, 0);

    // Overflow on core 0
    for (int i = 0; i < 16; i++) push4(i + 1, 0, 0, 0, 4'b0001);
    chk("ovf ready after 16", bus.in_ready, 4'hE);
    chk("ovf not yet", bus.ovf_err, 0);
    push4(99, 0, 0, 0, 4'b0001);
    chk("ovf sticky", bus.ovf_err, 4'h1);
    push4(0, 10, 20, 30, 4'b1110);
    tick();
    chk("ovf hold valid", bus.out_valid, 1);
    chk("ovf hold data", dout(0), 61);

    // Asynchronous reset mid-HOLD
    #2 reset = 1'b0;
    #1;
    chk("arst out_valid", bus.out_valid, 0);
    chk("arst in_ready", bus.in_ready, 4'hF);
    chk("arst red_cnt", bus.red_cnt, 0);
    chk("arst ovf_err", bus.ovf_err, 0);
    chk("arst out_data zero", bus.out_data == '0, 1);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Flushed FIFOs: a fresh set reduces alone
    push4(1, 1, 1, 1, 4'hF);
    tick();
    chk("post-rst data", dout(3), 4);
    chk("post-rst red_cnt", bus.red_cnt, 1);
    ack_all();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
